// File: rtl/spi_reg_slave.sv
// SPI slave register engine: command byte, then a burst of DATA_W-bit words
// into or out of a 2**ADDR_W register bank. Runs entirely on w_SPI_Clk.
module spi_reg_slave #(
  parameter int                   DATA_W  = 8,
  parameter int                   ADDR_W  = 4,
  parameter logic [2**ADDR_W-1:0] RO_MASK = '0,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic                         i_Rst_L,
  input  logic                         w_SPI_Clk,
  input  logic                         i_SPI_CS_n,
  input  logic                         i_SPI_MOSI,
  output logic                         o_SPI_MISO,
  output logic                         o_SPI_MISO_En,
  input  logic [2**ADDR_W*DATA_W-1:0]  i_Status,
  output logic [2**ADDR_W*DATA_W-1:0]  o_Regs,
  output logic                         o_Wr_Strobe,
  output logic [ADDR_W-1:0]            o_Wr_Addr,
  output logic [DATA_W-1:0]            o_Wr_Data,
  output logic [7:0]                   o_Word_Cnt
);
  localparam int NREG = 2**ADDR_W;
  localparam int CW   = $clog2(DATA_W);

  typedef enum logic {S_CMD, S_DATA} state_e;

  state_e              state_q;
  logic [CW-1:0]       bit_cnt_q;
  logic [7:0]          word_cnt_q;
  logic                miso_q;
  logic                strobe_q;
  logic [6:0]          cmd_sq;
  logic [DATA_W-2:0]   in_sq;
  logic [DATA_W-2:0]   out_sq;
  logic [ADDR_W-1:0]   addr_q;
  logic                rd_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   regs_q   [NREG];
  logic [DATA_W-1:0]   word_arr [NREG];

  logic                cmd_rd, last_cmd, last_word, wr_en;
  logic [ADDR_W-1:0]   cmd_addr, addr_nxt;
  logic [DATA_W-1:0]   cmd_word, nxt_word, data_word;

  // Read-back view: RO slots come straight from i_Status.
  always_comb begin
    for (int n = 0; n < NREG; n++)
      word_arr[n] = RO_MASK[n] ? i_Status[n*DATA_W +: DATA_W] : regs_q[n];
  end

  // Command decode uses the bit on the wire now so MISO is ready one edge early.
  assign cmd_rd    = cmd_sq[6];
  assign cmd_addr  = ADDR_W'({cmd_sq, i_SPI_MOSI});
  assign addr_nxt  = addr_q + ADDR_W'(1);
  assign cmd_word  = word_arr[cmd_addr];
  assign nxt_word  = word_arr[addr_nxt];
  assign data_word = {in_sq, i_SPI_MOSI};
  assign last_cmd  = (state_q == S_CMD)  && (bit_cnt_q == CW'(7));
  assign last_word = (state_q == S_DATA) && (bit_cnt_q == CW'(DATA_W-1));
  assign wr_en     = last_word && !rd_q && !RO_MASK[addr_q];

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
    if (!i_Rst_L) begin
      state_q    <= S_CMD;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      miso_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else if (i_SPI_CS_n) begin
      state_q    <= S_CMD;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      miso_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CMD: begin
          strobe_q <= 1'b0;
          if (last_cmd) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            miso_q    <= cmd_rd & cmd_word[DATA_W-1];
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
            miso_q    <= 1'b0;
          end
        end
        S_DATA: begin
          strobe_q <= wr_en;
          if (last_word) begin
            bit_cnt_q <= '0;
            if (word_cnt_q != 8'hFF) word_cnt_q <= word_cnt_q + 8'd1;
            miso_q    <= rd_q & nxt_word[DATA_W-1];
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
            miso_q    <= rd_q & out_sq[DATA_W-2];
          end
        end
        default: state_q <= S_CMD;
      endcase
    end
  end

  // Datapath and bank survive a CS abort; only i_Rst_L clears them.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cmd_sq    <= '0;
      in_sq     <= '0;
      out_sq    <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int n = 0; n < NREG; n++) regs_q[n] <= RST_VAL;
    end else begin
      cmd_sq <= {cmd_sq[5:0], i_SPI_MOSI};
      in_sq  <= {in_sq[DATA_W-3:0], i_SPI_MOSI};
      if (last_cmd) begin
        addr_q <= cmd_addr;
        rd_q   <= cmd_rd;
        out_sq <= cmd_word[DATA_W-2:0];
      end else if (last_word) begin
        addr_q <= addr_nxt;
        out_sq <= nxt_word[DATA_W-2:0];
      end else begin
        out_sq <= {out_sq[DATA_W-3:0], 1'b0};
      end
      if (wr_en) begin
        regs_q[addr_q] <= data_word;
        wr_addr_q      <= addr_q;
        wr_data_q      <= data_word;
      end
    end
  end

  for (genvar n = 0; n < NREG; n++) begin : g_regs
    assign o_Regs[n*DATA_W +: DATA_W] = RO_MASK[n] ? '0 : regs_q[n];
  end

  assign o_SPI_MISO_En = i_Rst_L & ~i_SPI_CS_n;
  assign o_SPI_MISO    = miso_q;
  assign o_Wr_Strobe   = strobe_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Data     = wr_data_q;
  assign o_Word_Cnt    = word_cnt_q;
endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- Parameterised SPI slave register engine, running entirely in the SPI clock domain.
- Decodes a command word followed by a burst of DATA_W-bit data words.
- Holds a register bank of 2**ADDR_W entries with auto-increment address and per-register read-only masking.
- Sits directly behind the SPI pins and presents a register bank and write strobes to fabric logic, which is responsible for the crossing into i_Clk.

Parameters:
- DATA_W, 8: data word width in bits, 8..32.
- ADDR_W, 4: register address width, 1..7. Bank holds 2**ADDR_W registers.
- RO_MASK, {2**ADDR_W{1'b0}}: bit n = 1 makes register n read-only; reads then return i_Status slice n.
- RST_VAL, 0: reset value of every writable register, DATA_W bits.

Ports:
- i_Rst_L  in  1  reset, asynchronous, active-low
- w_SPI_Clk  in  1  clock: mode-adjusted SPI clock; rising edge = MOSI capture edge
- i_SPI_CS_n  in  1  chip select, active low; high asynchronously aborts the frame
- i_SPI_MOSI  in  1  serial data in, MSB first
- o_SPI_MISO  out  1  serial data out, MSB first
- o_SPI_MISO_En  out  1  MISO output enable for pad tri-state
- i_Status  in  2**ADDR_W*DATA_W  read-only register sources; slice n = [n*DATA_W +: DATA_W]
- o_Regs  out  2**ADDR_W*DATA_W  flattened register bank; RO slices read 0
- o_Wr_Strobe  out  1  pulse: a register write completed
- o_Wr_Addr  out  ADDR_W  address of last write
- o_Wr_Data  out  DATA_W  data of last write
- o_Word_Cnt  out  8  data words completed in current frame, saturating at 255

Behaviour:
- Clock and reset
  - All state is updated on the rising edge of w_SPI_Clk.
  - i_Rst_L low clears all state asynchronously: writable registers = RST_VAL, all outputs 0.
- Frame abort (i_SPI_CS_n high)
  - Asynchronously forces state CMD, bit counter 0, o_Word_Cnt 0, o_SPI_MISO 0, o_SPI_MISO_En 0, o_Wr_Strobe 0.
  - Register bank, o_Wr_Addr and o_Wr_Data are retained.
  - An abort mid-word discards the partial word: no write, no increment.
- Command word
  - 8 bits: bit7 = R/nW (1 = read); bits[ADDR_W-1:0] = start address.
  - Command bits above ADDR_W are ignored.
- State CMD
  - Shifts 8 bits in; o_SPI_MISO = 0 and o_SPI_MISO_En = 1 while CS is low.
  - On the edge capturing command bit 0:
    - latch the address and direction;
    - go to state DATA;
    - if reading, load the output shift register with the target word (reg[addr], or the i_Status slice if RO) and drive its MSB on o_SPI_MISO.
  - The target word is selected from the combinational incoming command value, so the bit is valid before the next capture edge.
- State DATA
  - Shifts DATA_W bits per word.
  - Read: each capture edge drives the next lower bit.
  - On the edge completing a word:
    - address <= address + 1, wrapping modulo 2**ADDR_W (last register wraps to 0);
    - o_Word_Cnt increments;
    - if reading, load the next register's MSB onto MISO.
  - Write: on the edge completing a word, to a writable register:
    - reg[addr] <= received word, including the bit just captured;
    - o_Wr_Addr and o_Wr_Data updated;
    - o_Wr_Strobe = 1 for exactly one w_SPI_Clk cycle, cleared on the next edge or by CS high.
  - Write to an RO register: no bank change, no strobe, address still increments.
  - Read frames discard MOSI data and never strobe.
  - DATA stays in DATA until CS goes high; bursts are unbounded with wrap.
- Simultaneous events
  - i_Rst_L has priority over CS.
  - A write and a read of the same register cannot occur in one frame.
  - i_Status is sampled only when a word is loaded for output.
- o_Regs is driven from registers, with no combinational path from MOSI.

Test Plan:
- Reset: i_Rst_L low, RST_VAL = 8'h5A -> all writable o_Regs slices 8'h5A, o_Wr_Strobe 0, o_SPI_MISO_En 0.
- Write burst: CS low, cmd 8'h03, data 8'hA1, 8'hB2 -> reg3 = A1, reg4 = B2; two one-cycle strobes with addr 3 then 4; o_Word_Cnt = 2.
- Read wrap (ADDR_W = 4): preset reg15 = 8'h11, reg0 = 8'h22; cmd 8'h8F, 16 clocks -> MISO shows 0x11 then 0x22 MSB-first; no strobe.
- Read-only: RO_MASK bit 2 set, i_Status slice 2 = 8'hC3; write cmd 8'h02, data 8'hFF -> no strobe, o_Regs slice 2 = 0; read cmd 8'h82 -> MISO returns 0xC3.
- Abort mid-word: cmd 8'h05, 5 data bits, CS high -> reg5 unchanged, o_Word_Cnt 0, MISO_En 0; next frame decodes its command correctly.
- Reset mid-write: i_Rst_L pulsed low after 3 data bits -> registers return to RST_VAL; the following frame behaves normally.
